// File: rtl/lap_timer_pkg.sv
// lap_timer_pkg: state encoding and BCD digit limits shared by the lap timer
package lap_timer_pkg;
    typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, PAUSE = 2'd2} state_t;
    localparam logic [3:0] UNITS_MAX = 4'd9;
    localparam logic [3:0] TENS_MAX  = 4'd5;
endpackage

// File: rtl/lap_timer_bcd_digit.sv
// bcd_digit: one BCD digit counting 0..MAX, carry high when inc wraps it
// ports: clk, reset (async, high), clr (sync zero, beats inc), inc, q (digit), carry
module bcd_digit
    import lap_timer_pkg::*;
#(
    parameter logic [3:0] MAX = UNITS_MAX
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       clr,
    input  logic       inc,
    output logic [3:0] q,
    output logic       carry
);
    logic at_max;
    assign at_max = q >= MAX;
    assign carry  = inc && at_max;
    always_ff @(posedge clk or posedge reset)
        if (reset) q <= '0;
        else       q <= clr ? 4'd0 : !inc ? q : at_max ? 4'd0 : q + 4'd1;
endmodule

// File: rtl/lap_timer.sv
// lap_timer: seconds stopwatch 00..59 in BCD with start/pause, clear and lap capture
// ports: clk, reset (async, high), start_stop/lap/clear (1-cycle pulses),
//        time_bcd (live seconds), sample_in + sample_in_valid (lap capture strobe),
//        running (high in RUN)
module lap_timer
    import lap_timer_pkg::*;
#(
    parameter int CLK_PER_TICK = 100000000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start_stop,
    input  logic       lap,
    input  logic       clear,
    output logic [7:0] time_bcd,
    output logic [7:0] sample_in,
    output logic       sample_in_valid,
    output logic       running
);
    localparam int PW = CLK_PER_TICK > 1 ? $clog2(CLK_PER_TICK) : 1;
    localparam logic [PW-1:0] PSC_LAST = PW'(CLK_PER_TICK - 1);
    state_t        state, state_n;
    logic [PW-1:0] psc, psc_n;
    logic          tick, cap, units_carry, unused_wrap;
    logic [3:0]    units, tens;
    always_comb begin
        state_n = clear ? IDLE : !start_stop ? state : state == RUN ? PAUSE : RUN;
        tick    = state == RUN && psc == PSC_LAST;
        psc_n   = (clear || state == IDLE) ? '0 : state != RUN ? psc : tick ? '0 : psc + PW'(1);
        cap     = lap && !clear && state != IDLE;
    end
    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            state           <= IDLE;
            psc             <= '0;
            sample_in       <= '0;
            sample_in_valid <= 1'b0;
        end else begin
            state           <= state_n;
            psc             <= psc_n;
            sample_in       <= cap ? time_bcd : clear ? 8'h00 : sample_in;
            sample_in_valid <= cap;
        end
    bcd_digit #(.MAX(UNITS_MAX)) u_units (
        .clk(clk), .reset(reset), .clr(clear), .inc(tick), .q(units), .carry(units_carry)
    );
    bcd_digit #(.MAX(TENS_MAX)) u_tens (
        .clk(clk), .reset(reset), .clr(clear), .inc(units_carry), .q(tens), .carry(unused_wrap)
    );
    assign time_bcd = {tens, units};
    assign running  = state == RUN;
endmodule

// File: tb/tb_lap_timer.sv
// tb_lap_timer: scoreboard bench for lap_timer with a queue-based downstream stash
module tb_lap_timer;
    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       start_stop = 1'b0;
    logic       lap = 1'b0;
    logic       clear = 1'b0;
    logic [7:0] time_bcd, sample_in;
    logic       sample_in_valid, running;
    int         tests = 0;
    int         fails = 0;
    logic [7:0] exp_q[$];
    logic [7:0] lap_log[$];
    logic [7:0] stash[$];

    lap_timer #(.CLK_PER_TICK(4)) dut (
        .clk(clk), .reset(reset), .start_stop(start_stop), .lap(lap), .clear(clear),
        .time_bcd(time_bcd), .sample_in(sample_in), .sample_in_valid(sample_in_valid),
        .running(running)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulse_start;
        start_stop = 1'b1;
        step(1);
        start_stop = 1'b0;
    endtask

    task automatic restart;
        clear = 1'b1;
        step(1);
        clear = 1'b0;
        pulse_start();
    endtask

    task automatic do_lap(input logic [7:0] t);
        exp_q.push_back(t);
        lap_log.push_back(t);
        lap = 1'b1;
        step(1);
        lap = 1'b0;
    endtask

    // downstream stash: stores every strobed sample and scores it against the expected queue
    always @(negedge clk)
        if (sample_in_valid === 1'b1) begin
            stash.push_back(sample_in);
            if (exp_q.size() == 0) check("spurious_strobe", {7'd0, sample_in_valid}, 8'h00);
            else check("strobe_sample", sample_in, exp_q.pop_front());
        end

    initial begin
        step(2);
        check("rst_time", time_bcd, 8'h00);
        check("rst_sample", sample_in, 8'h00);
        check("rst_valid", {7'd0, sample_in_valid}, 8'h00);
        check("rst_running", {7'd0, running}, 8'h00);
        reset = 1'b0;
        step(5);
        check("idle_wait_time", time_bcd, 8'h00);
        check("idle_wait_running", {7'd0, running}, 8'h00);
        pulse_start();
        check("start_running", {7'd0, running}, 8'h01);
        step(40);
        check("forty_cycles", time_bcd, 8'h10);
        check("forty_no_strobe", {7'd0, sample_in_valid}, 8'h00);

        restart();
        step(4 * 59);
        check("at_59", time_bcd, 8'h59);
        step(4);
        check("wrap_00", time_bcd, 8'h00);

        restart();
        step(4 * 7);
        check("pre_lap_07", time_bcd, 8'h07);
        do_lap(8'h07);
        check("lap07_sample", sample_in, 8'h07);
        check("lap07_valid", {7'd0, sample_in_valid}, 8'h01);
        step(1);
        check("lap07_valid_drop", {7'd0, sample_in_valid}, 8'h00);
        check("lap07_hold", sample_in, 8'h07);

        restart();
        step(4 * 12);
        check("pre_lap_12", time_bcd, 8'h12);
        do_lap(8'h12);
        check("b2b_first_valid", {7'd0, sample_in_valid}, 8'h01);
        do_lap(8'h12);
        check("b2b_second_valid", {7'd0, sample_in_valid}, 8'h01);
        check("b2b_second_sample", sample_in, 8'h12);
        step(1);
        check("b2b_drop", {7'd0, sample_in_valid}, 8'h00);

        restart();
        step(4 * 3 + 2);
        pulse_start();
        check("pause_running", {7'd0, running}, 8'h00);
        step(20);
        check("pause_hold", time_bcd, 8'h03);
        do_lap(8'h03);
        check("pause_lap", sample_in, 8'h03);
        pulse_start();
        check("resume_running", {7'd0, running}, 8'h01);
        check("resume_time", time_bcd, 8'h03);
        step(1);
        check("resume_tick", time_bcd, 8'h04);

        restart();
        step(4 * 25);
        check("pre_clear_25", time_bcd, 8'h25);
        clear = 1'b1;
        lap = 1'b1;
        step(1);
        clear = 1'b0;
        lap = 1'b0;
        check("clear_valid", {7'd0, sample_in_valid}, 8'h00);
        check("clear_time", time_bcd, 8'h00);
        check("clear_running", {7'd0, running}, 8'h00);
        check("clear_sample", sample_in, 8'h00);

        lap = 1'b1;
        step(1);
        lap = 1'b0;
        check("idle_lap_valid", {7'd0, sample_in_valid}, 8'h00);
        step(1);
        check("idle_lap_valid_next", {7'd0, sample_in_valid}, 8'h00);

        pulse_start();
        step(4 * 33);
        check("pre_reset_33", time_bcd, 8'h33);
        lap = 1'b1;
        step(1);
        lap = 1'b0;
        check("pre_reset_strobe", {7'd0, sample_in_valid}, 8'h01);
        #2 reset = 1'b1;
        #1;
        check("async_time", time_bcd, 8'h00);
        check("async_sample", sample_in, 8'h00);
        check("async_valid", {7'd0, sample_in_valid}, 8'h00);
        check("async_running", {7'd0, running}, 8'h00);
        step(2);
        reset = 1'b0;
        step(8);
        check("post_reset_time", time_bcd, 8'h00);
        check("post_reset_running", {7'd0, running}, 8'h00);
        pulse_start();
        step(4);
        check("post_reset_count", time_bcd, 8'h01);

        step(2);
        check("exp_drained", 8'(exp_q.size()), 8'h00);
        check("stash_count", 8'(stash.size()), 8'(lap_log.size()));
        for (int i = 0; i < lap_log.size() && i < stash.size(); i++)
            check($sformatf("stash_%0d", i), stash[i], lap_log[i]);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/lap_timer.md
LAP_TIMER -- requirements
Module: lap_timer

Interface
REQ-001 The block SHALL have parameter CLK_PER_TICK, default 100000000, giving clk cycles per one-second tick (100 MHz board clock).
REQ-002 The block SHALL have port clk, input, 1, the single system clock; all state SHALL change on its rising edge.
REQ-003 The block SHALL have port reset, input, 1, asynchronous and active-high.
REQ-004 The block SHALL have port start_stop, input, 1, a one-cycle pulse that starts or pauses counting.
REQ-005 The block SHALL have port lap, input, 1, a one-cycle pulse that requests a capture of the current time.
REQ-006 The block SHALL have port clear, input, 1, a one-cycle pulse that returns to zero and idle.
REQ-007 The block SHALL have port time_bcd, output, 8, the live seconds count as two BCD digits: [7:4] tens, [3:0] units.
REQ-008 The block SHALL have port sample_in, output, 8, the captured BCD time for the downstream stash.
REQ-009 The block SHALL have port sample_in_valid, output, 1, a one-cycle strobe qualifying sample_in.
REQ-010 The block SHALL have port running, output, 1, high only in state RUN.

Function
REQ-011 The FSM SHALL have states IDLE, RUN and PAUSE.
- IDLE + start_stop -> RUN
- RUN + start_stop -> PAUSE
- PAUSE + start_stop -> RUN
- any state + clear -> IDLE
REQ-012 clear SHALL take priority over start_stop and lap in the same cycle: no capture strobe, counters zeroed.
REQ-013 Prescaler: counts 0..CLK_PER_TICK-1 only in RUN and emits an internal tick on the cycle it equals CLK_PER_TICK-1, then wraps to 0.
REQ-014 The prescaler SHALL hold its value in PAUSE and SHALL be zeroed in IDLE and on the IDLE->RUN transition.
REQ-015 On each tick the units digit SHALL increment; units 9 -> 0 SHALL carry into tens.
REQ-016 Seconds 0x59 on a tick SHALL wrap to 0x00, with no overflow flag.
REQ-017 The BCD digits SHALL never hold a value above 9 (units) or 5 (tens).
REQ-018 A lap in RUN or PAUSE SHALL register sample_in <= time_bcd value before this edge's update.
REQ-019 That lap SHALL assert sample_in_valid for exactly the next cycle, giving 1-cycle latency.
REQ-020 A lap in IDLE SHALL be ignored, and sample_in_valid SHALL stay 0.
REQ-021 lap coincident with start_stop SHALL capture the pre-transition time and SHALL also perform the transition.
REQ-022 lap coincident with a tick SHALL capture the pre-increment value.
REQ-023 sample_in SHALL hold its last captured value until the next capture or until reset/clear.
REQ-024 Back-to-back lap pulses SHALL produce back-to-back strobes, with no back-pressure.

Reset
REQ-025 On reset high, asynchronously: state=IDLE, prescaler=0, time_bcd=0x00, sample_in=0x00, sample_in_valid=0, running=0.
REQ-026 Reset asserted mid-count SHALL discard the count and any pending strobe.
REQ-027 After reset deasserts, the block SHALL await start_stop.
REQ-028 clear SHALL produce the same values as reset, but synchronously.

Structure
REQ-029 A shared package lap_timer_pkg SHALL hold the state encoding (IDLE=2'd0, RUN=2'd1, PAUSE=2'd2) and the BCD limits (UNITS_MAX=9, TENS_MAX=5).
REQ-030 One sub-module, bcd_digit, SHALL implement a single 4-bit BCD digit counter with parameter MAX, inputs inc/clr, and a carry output.
REQ-031 lap_timer SHALL instantiate bcd_digit twice, for units and tens.

Verification (CLK_PER_TICK=4, clk period 10 ns)
REQ-032 Scenario: reset then start_stop pulse -> running=1; after 40 cycles time_bcd=0x10; sample_in_valid=0 throughout.
REQ-033 Scenario: run 60 ticks -> time_bcd passes 0x59 then reads 0x00.
REQ-034 Scenario: lap at time_bcd=0x07 -> next cycle sample_in=0x07 with sample_in_valid=1 for exactly one cycle.
REQ-035 Scenario: two consecutive lap pulses at 0x12 -> two strobes, both with sample_in=0x12.
REQ-036 Scenario: start_stop at 0x03 (PAUSE) held 20 cycles -> time_bcd stays 0x03; lap gives sample_in=0x03.
REQ-037 Scenario: a second start_stop resumes counting, and 0x04 appears after the remaining prescaler count.
REQ-038 Scenario: clear+lap in the same cycle at 0x25 -> no strobe; time_bcd=0x00; running=0.
REQ-039 Scenario: lap in IDLE -> no strobe.
REQ-040 Scenario: reset asserted mid-RUN at 0x33, off a clock edge -> outputs zero immediately, with no clock edge needed.
REQ-041 The bench SHALL pass sample_in/sample_in_valid into a Stash instance and check that the stored samples match the captured lap values in order.
